// File: rtl/counter_ctrl_defs.sv
// Shared definitions for the counter controller: FSM state encodings and the
// default counter/period width.
package counter_ctrl_defs;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam int DEFAULT_WIDTH = 4;

endpackage

// File: rtl/ctrl_counter.sv
// Counter datapath for counter_ctrl: a synchronous clear that wins over the
// increment enable, with an asynchronous active-low clear-to-zero reset.
module ctrl_counter
  import counter_ctrl_defs::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = count_q + {{(WIDTH-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/counter_ctrl.sv
// One-shot / periodic terminal-count controller: three-state FSM, latched
// period and mode, and the terminal-count comparator around ctrl_counter.
module counter_ctrl
  import counter_ctrl_defs::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             halt,
  input  logic             mode,
  input  logic [WIDTH-1:0] period,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             tc,
  output logic             done
);

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] period_q;
  logic [WIDTH-1:0] period_d;
  logic             mode_q;
  logic             mode_d;
  logic             cnt_clr;
  logic             cnt_en;
  logic             period_nonzero;

  ctrl_counter #(
    .WIDTH (WIDTH)
  ) u_counter (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .count (count)
  );

  assign period_nonzero = (period != '0);
  assign tc             = (state_q == RUN) && (count == period_q);
  assign busy           = (state_q == RUN);
  assign done           = (state_q == DONE);

  // Halt overrides everything; IDLE and DONE share the start-acceptance rule.
  always_comb begin
    state_d  = state_q;
    period_d = period_q;
    mode_d   = mode_q;
    cnt_clr  = 1'b0;
    cnt_en   = 1'b0;
    if (halt) begin
      state_d = IDLE;
      cnt_clr = 1'b1;
    end else begin
      unique case (state_q)
        RUN: begin
          if (tc) begin
            if (mode_q) begin
              cnt_clr = 1'b1;
            end else begin
              state_d = DONE;
            end
          end else begin
            cnt_en = (count < period_q);
          end
        end
        IDLE, DONE: begin
          if (start) begin
            cnt_clr = 1'b1;
            if (period_nonzero) begin
              state_d  = RUN;
              period_d = period;
              mode_d   = mode;
            end else begin
              state_d = IDLE;
            end
          end else if (state_q == IDLE) begin
            cnt_clr = 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_clr = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      period_q <= '0;
      mode_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      period_q <= period_d;
      mode_q   <= mode_d;
    end
  end

endmodule
